// File: rtl/ram_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port registered-read RAM.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_valid,
    output logic                  f_ready,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_resp_valid,
    output logic [31:0]           f_rdata,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [1:0]            d_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_resp_valid,
    output logic [31:0]           d_rdata,
    output logic [1:0]            mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] MEM_READ       = 2'd0;
    localparam logic [1:0] MEM_WRITE_WORD = 2'd1;
    localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
    localparam logic [1:0] MEM_WRITE_BYTE = 2'd3;
    localparam logic       PORT_F         = 1'b0;
    localparam logic       PORT_D         = 1'b1;

    logic       last_grant;
    logic       grant_d;
    logic       accept;
    // [0] = issue stage (request on mem_*), [1] = response stage (mem_rdata valid)
    logic [1:0] vld_pipe;
    logic [1:0] tag_pipe;
    logic [1:0] rd_pipe;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign grant_d = d_valid && (!f_valid || last_grant == PORT_F);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant_d = d_valid;
`endif

    assign d_ready = !rst && grant_d;
    assign f_ready = !rst && f_valid && !grant_d;
    assign accept  = f_ready || d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            tag_pipe   <= '0;
            rd_pipe    <= '0;
            last_grant <= PORT_D;
            mem_mode   <= MEM_READ;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            tag_pipe <= {tag_pipe[0], d_ready};
            rd_pipe  <= {rd_pipe[0], !(d_ready && d_mode != MEM_READ)};
            if (accept)
                last_grant <= d_ready ? PORT_D : PORT_F;
            if (d_ready) begin
                mem_mode  <= d_mode;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (f_ready) begin
                mem_mode  <= MEM_READ;
                mem_addr  <= f_addr;
                mem_wdata <= '0;
            end else begin
                mem_mode  <= MEM_READ;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

    // Response flags are masked during reset so nothing in flight escapes.
    assign f_resp_valid = !rst && vld_pipe[1] && tag_pipe[1] == PORT_F;
    assign d_resp_valid = !rst && vld_pipe[1] && tag_pipe[1] == PORT_D;
    assign f_rdata      = f_resp_valid ? mem_rdata : 32'd0;
    assign d_rdata      = (d_resp_valid && rd_pipe[1]) ? mem_rdata : 32'd0;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The parameter list SHALL be one per line:
- ADDR_WIDTH, 5, RAM byte-address width.
REQ-002 The port list SHALL be one per line:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- f_valid  in  1  fetch port request present.
- f_ready  out  1  fetch request accepted this cycle.
- f_addr  in  ADDR_WIDTH  fetch byte address (always a word read).
- f_resp_valid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- d_valid  in  1  data port request present.
- d_ready  out  1  data request accepted this cycle.
- d_mode  in  2  memory mode code: MEM_READ, MEM_WRITE_WORD, MEM_WRITE_HALF or MEM_WRITE_BYTE.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  32  write data; low bytes used for half/byte writes.
- d_resp_valid  out  1  data response valid (reads and writes).
- d_rdata  out  32  data read data; 0 for writes.
- mem_mode  out  2  registered RAM mode.
- mem_addr  out  ADDR_WIDTH  registered RAM address.
- mem_wdata  out  32  registered RAM write value.
- mem_rdata  in  32  RAM registered read value.

Function
REQ-003 Handshake: a request SHALL transfer on a cycle where valid and ready are both high; ready SHALL depend combinationally on valid and arbiter state only, never on addr/data.
REQ-004 At most one of f_ready/d_ready SHALL be high per cycle; one request SHALL be accepted per cycle when any valid is high (full throughput).
REQ-005 Issue stage: on accept at edge N, mem_mode/addr/wdata SHALL present the request from N to N+1, and a 1-bit tag (F/D) plus a valid flag SHALL register alongside it.
REQ-006 Idle cycles (no accept) SHALL drive mem_mode=MEM_READ, mem_addr=0, mem_wdata=0, with the issue valid flag low.
REQ-007 Response stage: the request issued at edge N SHALL be sampled by the RAM at edge N+1, and the matching resp_valid SHALL be high for exactly one cycle after edge N+1 with rdata=mem_rdata (fixed latency 2 from accept).
REQ-008 For data writes, d_resp_valid SHALL pulse at the same latency with d_rdata=0.
REQ-009 Responses SHALL have no backpressure; requesters SHALL always accept them, and the response order per port SHALL equal the accept order.
REQ-010 Both resp_valid outputs SHALL never be high in the same cycle.
REQ-011 Arbitration state: a 1-bit last_grant register SHALL update on every accept to the winning port.
REQ-012 Back-to-back: write to address A accepted at N followed by a read of A at N+1 SHALL return the written data (RAM order preserves this; no forwarding logic).
REQ-013 Address wrap: addresses SHALL be passed unmodified; multi-byte wrap at 2^ADDR_WIDTH is the RAM's behaviour.

Reset
REQ-014 While rst is high: f_ready=d_ready=0, issue and response valid flags=0, mem_mode=MEM_READ, mem_addr=0, mem_wdata=0, rdata outputs=0, last_grant=D.
REQ-015 Reset mid-operation SHALL drop in-flight requests with no response pulse; the first accept is possible in the cycle after rst deasserts.

Configuration
REQ-016 Macro MEM_ARB_ROUND_ROBIN_EN defined: if both ports are valid, the port not equal to last_grant SHALL win.
REQ-017 Macro MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority SHALL apply, with the data port always beating the fetch port, and last_grant kept but unused.

Verification
REQ-018 Reset then f_valid only, f_addr=4, with RAM bytes 4..7=11,22,33,44 -> f_ready same cycle, then f_resp_valid two cycles later with f_rdata=0x11223344.
REQ-019 d WRITE_WORD addr 8 data 0xDEADBEEF, then d READ addr 8 next cycle -> two d_resp_valid pulses on consecutive cycles, the second with d_rdata=0xDEADBEEF.
REQ-020 Both valid for 4 cycles, with MEM_ARB_ROUND_ROBIN_EN defined -> grants F,D,F,D starting from reset last_grant=D; with it undefined -> D,D,D,D and f_ready low.
REQ-021 d WRITE_BYTE addr 3 data 0x000000AB, then f read addr 0 -> f_rdata byte lane [7:0]=0xAB, other bytes unchanged.
REQ-022 rst asserted one cycle after an accept -> no resp_valid pulse for that request, and mem_mode=MEM_READ/addr=0 during reset.
REQ-023 Idle 5 cycles -> no ready pulses and no resp_valid pulses, with mem_mode held at MEM_READ and mem_addr held at 0.
